// File: rtl/canvas_pkg.sv
// Shared canvas geometry, state encoding and cell addressing for the canvas write path.
// The top level sizes itself from these defaults.
package canvas_pkg;

   localparam int GRID_W       = 32;
   localparam int GRID_H       = 32;
   localparam int COLOR_W      = 24;
   localparam int ADDR_W       = 10;
   localparam int CANVAS_CELLS = GRID_W * GRID_H;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } canvas_state_t;

   typedef logic [COLOR_W-1:0] color_t;

   // Row-major cell index; a power-of-two width reduces the row product to a shift.
   function automatic int cell_addr(input int x, input int y, input int grid_w = GRID_W);
      if ((grid_w & (grid_w - 1)) == 0) begin
         return (y << $clog2(grid_w)) + x;
      end
      return y * grid_w + x;
   endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Address counter for the full-canvas clear sweep.
// It flags the final cell and wraps back to zero when that cell is consumed.
module clear_sweeper
   import canvas_pkg::*;
#(
   parameter int SW_ADDR_W = ADDR_W,
   parameter int CELLS     = CANVAS_CELLS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 run_i,
   output logic [SW_ADDR_W-1:0] next_o,
   output logic                 last_o
);

   localparam logic [SW_ADDR_W-1:0] LAST_ADDR = SW_ADDR_W'(CELLS - 1);

   logic [SW_ADDR_W-1:0] count_q, count_d;

   assign last_o = (count_q == LAST_ADDR);
   assign next_o = count_q + SW_ADDR_W'(1);

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (start_i) begin
         count_d = '0;
      end else if (run_i) begin
         count_d = last_o ? '0 : next_o;
      end
   end

   // NOTE: non-blocking assignment for state, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/canvas_writer.sv
// Write-side front end of the canvas RAM.
// Turns paint, erase and clear requests into registered write transactions, including the full clear sweep.
module canvas_writer #(
   parameter int GRID_W  = canvas_pkg::GRID_W,
   parameter int GRID_H  = canvas_pkg::GRID_H,
   parameter int COLOR_W = canvas_pkg::COLOR_W,
   parameter int ADDR_W  = canvas_pkg::ADDR_W
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic               paint_pulse,
   input  logic               erase_pulse,
   input  logic               clear_req,
   input  logic [5:0]         cursor_x,
   input  logic [4:0]         cursor_y,
   input  logic [COLOR_W-1:0] color_in,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               busy,
   output logic               clear_done
);

   localparam logic [1:0] S_IDLE  = 2'(canvas_pkg::IDLE);
   localparam logic [1:0] S_CLEAR = 2'(canvas_pkg::CLEAR);
   localparam logic [1:0] S_DONE  = 2'(canvas_pkg::DONE);

   logic [1:0]         state_q, state_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [COLOR_W-1:0] wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic              sw_start, sw_run, sw_last;
   logic [ADDR_W-1:0] sw_next;

   logic              in_range, reset_col;
   logic [ADDR_W-1:0] cursor_addr;

   assign in_range    = (int'(cursor_x) < GRID_W) && (int'(cursor_y) < GRID_H);
   assign reset_col   = (int'(cursor_x) == GRID_W);
   assign cursor_addr = ADDR_W'(canvas_pkg::cell_addr(int'(cursor_x), int'(cursor_y), GRID_W));

   clear_sweeper #(
      .SW_ADDR_W (ADDR_W),
      .CELLS     (GRID_W * GRID_H)
   ) u_sweeper (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .start_i (sw_start),
      .run_i   (sw_run),
      .next_o  (sw_next),
      .last_o  (sw_last)
   );

   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      sw_start  = 1'b0;
      sw_run    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (clear_req || (paint_pulse && reset_col)) begin
               state_d   = S_CLEAR;
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_data_d = '0;
               busy_d    = 1'b1;
               sw_start  = 1'b1;
            end else if ((erase_pulse || paint_pulse) && in_range) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cursor_addr;
               wr_data_d = erase_pulse ? '0 : color_in;
            end
         end
         // Requests are ignored for the whole sweep; the counter tracks the address on the bus.
         S_CLEAR: begin
            sw_run = 1'b1;
            if (sw_last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = sw_next;
               wr_data_d = '0;
               busy_d    = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: every output register is reset, so nothing leaves reset undefined.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign clear_done = done_q;

endmodule

// File: tb/tb_canvas_writer.sv
// Randomised, self-checking bench for canvas_writer against a transaction-level model of the canvas writer.
module tb_canvas_writer;

   localparam int CELLS = 32 * 32;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        paint_pulse = 1'b0;
   logic        erase_pulse = 1'b0;
   logic        clear_req = 1'b0;
   logic [5:0]  cursor_x = '0;
   logic [4:0]  cursor_y = '0;
   logic [23:0] color_in = '0;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [23:0] wr_data;
   logic        busy;
   logic        clear_done;

   canvas_writer dut (
      .CLOCK_50    (CLOCK_50),
      .reset_n     (reset_n),
      .paint_pulse (paint_pulse),
      .erase_pulse (erase_pulse),
      .clear_req   (clear_req),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .color_in    (color_in),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .clear_done  (clear_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int errors = 0;
   int checks = 0;
   int writes = 0;

   // Model: what the write port shows after each clock edge.
   bit          m_en, m_busy, m_done;
   int          m_addr;
   logic [23:0] m_data;
   int          m_left;   // sweep writes still to come
   bit          m_pend;   // clear_done owed after the final sweep write
   bit          m_drop;   // cycle during which clear_done is shown; requests are lost

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_busy = 0; m_done = 0; m_addr = 0; m_data = '0;
      m_left = 0; m_pend = 0; m_drop = 0;
   endtask

   task automatic model_sweep_write();
      m_en   = 1;
      m_busy = 1;
      m_done = 0;
      m_data = '0;
      m_addr = CELLS - m_left;
      m_left--;
      if (m_left == 0) m_pend = 1;
   endtask

   task automatic model_update(input bit p, input bit e, input bit c,
                               input int x, input int y, input logic [23:0] col);
      if (m_left > 0) begin
         model_sweep_write();
      end else if (m_pend) begin
         m_pend = 0; m_drop = 1;
         m_en = 0; m_busy = 0; m_done = 1;
      end else begin
         m_en = 0; m_busy = 0; m_done = 0;
         if (m_drop) begin
            m_drop = 0;
         end else if (c || (p && x == 32)) begin
            m_left = CELLS;
            model_sweep_write();
         end else if ((p || e) && x < 32 && y < 32) begin
            m_en   = 1;
            m_addr = y * 32 + x;
            m_data = e ? 24'h0 : col;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".wr_en"},      32'(wr_en),      32'(m_en));
      check({tag, ".wr_addr"},    32'(wr_addr),    32'(m_addr));
      check({tag, ".wr_data"},    32'(wr_data),    32'(m_data));
      check({tag, ".busy"},       32'(busy),       32'(m_busy));
      check({tag, ".clear_done"}, 32'(clear_done), 32'(m_done));
   endtask

   task automatic step(input string tag, input bit p, input bit e, input bit c,
                       input logic [5:0] x, input logic [4:0] y, input logic [23:0] col);
      paint_pulse = p; erase_pulse = e; clear_req = c;
      cursor_x = x; cursor_y = y; color_in = col;
      @(posedge CLOCK_50);
      #1;
      model_update(p, e, c, int'(x), int'(y), col);
      compare_all(tag);
      if (wr_en === 1'b1) writes++;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 6'd0, 5'd0, 24'h0);
   endtask

   task automatic rand_step(input string tag);
      int r;
      logic [5:0] x;
      r = $urandom_range(0, 39);
      if (r == 0)     x = 6'd32;
      else if (r < 5) x = 6'($urandom_range(33, 63));
      else            x = 6'($urandom_range(0, 31));
      step(tag, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0), x, 5'($urandom), 24'($urandom));
   endtask

   // Runs from the first sweep write until clear_done, with random requests injected mid-sweep.
   task automatic run_sweep(input string tag, input int extra_clear_at,
                            output int nwrites, output bit seen_done);
      seen_done = 0;
      for (int i = 1; i < 1200 && !seen_done; i++) begin
         step(tag, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              (i == extra_clear_at), 6'($urandom_range(0, 32)), 5'($urandom), 24'($urandom));
         if (clear_done === 1'b1) seen_done = 1;
      end
      nwrites = writes;
   endtask

   initial begin
      int  n;
      bit  seen;
      bit  found;

      model_reset();
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("rst.wr_en", 32'(wr_en), 0);
      check("rst.wr_addr", 32'(wr_addr), 0);
      check("rst.wr_data", 32'(wr_data), 0);
      check("rst.busy", 32'(busy), 0);
      check("rst.clear_done", 32'(clear_done), 0);
      reset_n = 1'b1;
      idle("idle", 10);

      step("paint", 1, 0, 0, 6'd5, 5'd3, 24'hFF8000);
      check("paint_en", 32'(wr_en), 1);
      check("paint_addr", 32'(wr_addr), 101);
      check("paint_data", 32'(wr_data), 32'h00FF8000);
      idle("paint_after", 1);
      check("paint_one_cycle", 32'(wr_en), 0);

      step("collide", 1, 1, 0, 6'd31, 5'd31, 24'h123456);
      check("collide_addr", 32'(wr_addr), 1023);
      check("collide_data", 32'(wr_data), 0);
      step("oor", 1, 0, 0, 6'd33, 5'd4, 24'hABCDEF);
      check("oor_no_write", 32'(wr_en), 0);
      step("erase_col32", 0, 1, 0, 6'd32, 5'd4, 24'h0);
      check("erase_col32_no_write", 32'(wr_en), 0);

      writes = 0;
      step("colclr", 1, 0, 0, 6'd32, 5'd7, 24'h55AA55);
      check("colclr_busy", 32'(busy), 1);
      check("colclr_first_addr", 32'(wr_addr), 0);
      run_sweep("colclr", 0, n, seen);
      check("colclr_done_seen", 32'(seen), 1);
      check("colclr_writes", 32'(n), CELLS);
      step("in_done", 1, 0, 0, 6'd2, 5'd2, 24'h777777);
      check("done_req_dropped", 32'(wr_en), 0);

      idle("pre_abort", 2);
      step("abort", 0, 0, 1, 6'd0, 5'd0, 24'h0);
      found = 0;
      for (int i = 0; i < 1100 && !found; i++) begin
         if (wr_en === 1'b1 && wr_addr == 10'd500) found = 1;
         else step("abort", 0, 0, 0, 6'($urandom_range(0, 31)), 5'($urandom), 24'h0);
      end
      check("abort_reached_500", 32'(found), 1);
      reset_n = 1'b0;
      #2;
      model_reset();
      compare_all("abort_async");
      repeat (2) @(posedge CLOCK_50);
      #1;
      reset_n = 1'b1;
      writes = 0;
      idle("post_abort", 8);
      check("post_abort_writes", 32'(writes), 0);
      check("post_abort_busy", 32'(busy), 0);

      writes = 0;
      step("clr2", 0, 0, 1, 6'd0, 5'd0, 24'h0);
      run_sweep("clr2", 300, n, seen);
      check("clr2_done_seen", 32'(seen), 1);
      check("clr2_writes", 32'(n), CELLS);
      idle("clr2_done", 1);
      writes = 0;
      step("clr3", 0, 0, 1, 6'd0, 5'd0, 24'h0);
      check("clr3_restart_addr", 32'(wr_addr), 0);
      run_sweep("clr3", 0, n, seen);
      check("clr3_done_seen", 32'(seen), 1);
      check("clr3_writes", 32'(n), CELLS);

      for (int i = 0; i < 4000; i++) rand_step("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
